// File: rtl/jpeg_pkg.sv
// Shared definitions for the JPEG per-block sequencer.
// Contents:
//   seq_state_t          - block sequencer FSM states
//   COMP_Y/COMP_CB/COMP_CR - component ids reported on comp_id
//   BLOCK_ROWS           - rows in one 8x8 block
//   max_int              - helper for sizing counters from parameters
package jpeg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DCT,
        ST_DEND,
        ST_QUANT,
        ST_HSTART,
        ST_HWAIT,
        ST_DONE
    } seq_state_t;

    localparam logic [1:0] COMP_Y  = 2'd0;
    localparam logic [1:0] COMP_CB = 2'd1;
    localparam logic [1:0] COMP_CR = 2'd2;

    localparam int BLOCK_ROWS = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/jpeg_mcu_counter.sv
// Block index counter for one MCU (luma blocks, then Cb blocks, then Cr blocks).
// Ports:
//   clock, reset  - rising-edge clock, synchronous active-high reset (index -> 0)
//   advance       - step to the next block (asserted during the block's DONE cycle)
//   comp_id       - component of the current block (COMP_Y/COMP_CB/COMP_CR)
//   is_luminance  - current block is Y
//   mcu_end       - advance on the last block of the MCU; the index wraps to 0
module jpeg_mcu_counter
    import jpeg_pkg::*;
#(
    parameter int LUMA_BLOCKS   = 4,
    parameter int CHROMA_BLOCKS = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       advance,
    output logic [1:0] comp_id,
    output logic       is_luminance,
    output logic       mcu_end
);

    localparam int TOTAL = LUMA_BLOCKS + 2 * CHROMA_BLOCKS;
    localparam int B_W   = (TOTAL > 1) ? $clog2(TOTAL) : 1;

    logic [B_W-1:0] b;
    logic           last;

    assign last = (int'(b) == TOTAL - 1);

    always_ff @(posedge clock) begin
        if (reset) begin
            b <= '0;
        end else if (advance) begin
            b <= last ? '0 : b + B_W'(1);
        end
    end

    always_comb begin
        comp_id = COMP_Y;
        if (int'(b) >= LUMA_BLOCKS + CHROMA_BLOCKS) begin
            comp_id = COMP_CR;
        end else if (int'(b) >= LUMA_BLOCKS) begin
            comp_id = COMP_CB;
        end
    end

    assign is_luminance = (comp_id == COMP_Y);
    assign mcu_end      = advance & last;

endmodule

// File: rtl/jpeg_block_sequencer.sv
// Per-block control sequencer for the JPEG encode pipeline. For each accepted
// 8x8 block it walks LOAD -> DCT -> DEND -> QUANT -> HSTART -> HWAIT -> DONE,
// emitting one Moore strobe per phase, and supervises Huffman completion with
// a timeout. Component id / luminance come from the MCU layout counter.
// Ports:
//   clock, reset         - rising-edge clock, synchronous active-high reset
//   blk_valid/blk_ready  - block handshake (see below)
//   huffman_done         - Huffman finished; only looked at in HWAIT
//   load_enable          - input block buffer capture (LOAD)
//   dct_enable           - DCT run enable (DCT, DCT_LATENCY cycles)
//   dct_end_enable       - DCT result buffer capture (DEND)
//   matrix_row           - quantizer row select, min(q,7) in QUANT, else 0
//   zigzag_input_enable  - zigzag row write, 8 strobes once quantizer output is valid
//   huffman_start        - Huffman start pulse (HSTART)
//   is_luminance,comp_id - component of the current block
//   blk_done, mcu_end    - block completion pulse / last block of the MCU
//   err_timeout          - sticky Huffman timeout flag
//
// Handshake: a block transfers on a cycle where blk_valid and blk_ready are
// both 1. blk_ready is 1 only in IDLE and depends on state alone, so a
// blk_valid held high is taken on every IDLE cycle and there is no input to
// output combinational path.
module jpeg_block_sequencer
    import jpeg_pkg::*;
#(
    parameter int DCT_LATENCY   = 8,
    parameter int QUANT_LATENCY = 1,
    parameter int LUMA_BLOCKS   = 4,
    parameter int CHROMA_BLOCKS = 1,
    parameter int HUFF_TIMEOUT  = 1024
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       blk_valid,
    output logic       blk_ready,
    input  logic       huffman_done,
    output logic       load_enable,
    output logic       dct_enable,
    output logic       dct_end_enable,
    output logic [7:0] matrix_row,
    output logic       zigzag_input_enable,
    output logic       huffman_start,
    output logic       is_luminance,
    output logic [1:0] comp_id,
    output logic       blk_done,
    output logic       mcu_end,
    output logic       err_timeout
);

    localparam int QUANT_LAST = BLOCK_ROWS - 1 + QUANT_LATENCY;
    localparam int CNT_MAX    = max_int(max_int(DCT_LATENCY, QUANT_LAST + 1), HUFF_TIMEOUT);
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    seq_state_t       state;
    seq_state_t       state_n;
    logic [CNT_W-1:0] cnt;       // cycles spent in the current state
    logic             timeout_hit;
    logic             advance;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            err_timeout <= 1'b0;
        end else begin
            state <= state_n;
            // Every state change restarts the per-state counter.
            if (state_n != state || state == ST_IDLE) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            if (timeout_hit) begin
                err_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        state_n             = state;
        timeout_hit         = 1'b0;
        blk_ready           = 1'b0;
        load_enable         = 1'b0;
        dct_enable          = 1'b0;
        dct_end_enable      = 1'b0;
        matrix_row          = 8'd0;
        zigzag_input_enable = 1'b0;
        huffman_start       = 1'b0;
        blk_done            = 1'b0;
        unique case (state)
            ST_IDLE: begin
                blk_ready = 1'b1;
                if (blk_valid) state_n = ST_LOAD;
            end
            ST_LOAD: begin
                load_enable = 1'b1;
                state_n     = ST_DCT;
            end
            ST_DCT: begin
                dct_enable = 1'b1;
                if (int'(cnt) == DCT_LATENCY - 1) state_n = ST_DEND;
            end
            ST_DEND: begin
                dct_end_enable = 1'b1;
                state_n        = ST_QUANT;
            end
            ST_QUANT: begin
                // Row select saturates at the last row while the quantizer
                // pipeline drains; zigzag writes lag by QUANT_LATENCY.
                matrix_row = (int'(cnt) > BLOCK_ROWS - 1) ? 8'(BLOCK_ROWS - 1) : 8'(cnt);
                zigzag_input_enable = (int'(cnt) >= QUANT_LATENCY);
                if (int'(cnt) == QUANT_LAST) state_n = ST_HSTART;
            end
            ST_HSTART: begin
                huffman_start = 1'b1;
                state_n       = ST_HWAIT;
            end
            ST_HWAIT: begin
                // A done on the final allowed cycle wins over the timeout.
                if (huffman_done) begin
                    state_n = ST_DONE;
                end else if (int'(cnt) == HUFF_TIMEOUT - 1) begin
                    state_n     = ST_DONE;
                    timeout_hit = 1'b1;
                end
            end
            ST_DONE: begin
                blk_done = 1'b1;
                state_n  = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign advance = (state == ST_DONE);

    jpeg_mcu_counter #(
        .LUMA_BLOCKS  (LUMA_BLOCKS),
        .CHROMA_BLOCKS(CHROMA_BLOCKS)
    ) u_mcu_counter (
        .clock       (clock),
        .reset       (reset),
        .advance     (advance),
        .comp_id     (comp_id),
        .is_luminance(is_luminance),
        .mcu_end     (mcu_end)
    );

endmodule
